// File: rtl/sid_regfile_if.sv
// CPU-side bus of one SID register file.
//   cs, we, addr, data_in : access request, sampled on the clock edge
//   data_out, rd_valid    : registered read response (one-cycle rd_valid pulse)
interface sid_regfile_if;
    logic       cs;
    logic       we;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rd_valid;

    modport master (output cs, we, addr, data_in, input  data_out, rd_valid);
    modport slave  (input  cs, we, addr, data_in, output data_out, rd_valid);
endinterface

// File: rtl/sid_regfile.sv
// Register writer/reader for one SID instance (3 voices + filter/volume).
//   clock, reset (async, active low), ce_1m (1 MHz enable, decay timing only)
//   bus            : CPU access interface (slave side)
//   freq_lo..sus_rel : per-voice register buses, voice n in bits [8n+7:8n]
//   fc_lo, fc_hi, res_filt, mode_vol : filter/volume registers 0x15-0x18
//   pot_x, pot_y, osc3, env3 : read-only sources for 0x19-0x1C
// Reads are serviced in two stages: the request edge captures the read
// value (and loads the bus latch for read-only sources), the following edge
// presents it on data_out with a rd_valid pulse.
module sid_regfile #(
    parameter logic [15:0] DECAY_CYCLES = 16'd8192
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce_1m,
    sid_regfile_if.slave  bus,
    output logic [23:0]   freq_lo,
    output logic [23:0]   freq_hi,
    output logic [23:0]   pw_lo,
    output logic [23:0]   pw_hi,
    output logic [23:0]   control,
    output logic [23:0]   att_dec,
    output logic [23:0]   sus_rel,
    output logic [7:0]    fc_lo,
    output logic [7:0]    fc_hi,
    output logic [7:0]    res_filt,
    output logic [7:0]    mode_vol,
    input  logic [7:0]    pot_x,
    input  logic [7:0]    pot_y,
    input  logic [7:0]    osc3,
    input  logic [7:0]    env3
);
    localparam int NUM_REGS = 25;   // writable registers 0x00-0x18

    logic [7:0]  r_regs [NUM_REGS];
    logic [7:0]  r_latch;
    logic [15:0] r_cnt;
    logic        r_rd_pend;
    logic [7:0]  r_rd_data;
    logic [7:0]  r_data_out;
    logic        r_rd_valid;

    logic        w_wr;
    logic        w_rd;
    logic        w_ro;
    logic [7:0]  w_ro_val;

    assign w_wr = bus.cs &  bus.we;
    assign w_rd = bus.cs & ~bus.we;
    assign w_ro = (bus.addr >= 5'h19) && (bus.addr <= 5'h1C);

    always_comb begin
        w_ro_val = 8'h00;
        case (bus.addr)
            5'h19:   w_ro_val = pot_x;
            5'h1A:   w_ro_val = pot_y;
            5'h1B:   w_ro_val = osc3;
            5'h1C:   w_ro_val = env3;
            default: w_ro_val = 8'h00;
        endcase
    end

    // Writable registers; writes above 0x18 match no entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
        end else if (w_wr) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (bus.addr == 5'(i)) r_regs[i] <= bus.data_in;
        end
    end

    // Bus latch and decay counter. Any cs cycle suppresses decay; only
    // writes and read-only-source reads reload it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_latch <= 8'h00;
            r_cnt   <= 16'd0;
        end else if (w_wr) begin
            r_latch <= bus.data_in;
            r_cnt   <= DECAY_CYCLES;
        end else if (w_rd && w_ro) begin
            r_latch <= w_ro_val;
            r_cnt   <= DECAY_CYCLES;
        end else if (!bus.cs && ce_1m && r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) r_latch <= 8'h00;
        end
    end

    // Read pipeline: capture at the request edge, present one edge later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_data  <= 8'h00;
            r_data_out <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_pend  <= w_rd;
            if (w_rd) r_rd_data <= w_ro ? w_ro_val : r_latch;
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) r_data_out <= r_rd_data;
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;

    for (genvar v = 0; v < 3; v++) begin : g_voice
        assign freq_lo[8*v +: 8] = r_regs[7*v + 0];
        assign freq_hi[8*v +: 8] = r_regs[7*v + 1];
        assign pw_lo  [8*v +: 8] = r_regs[7*v + 2];
        assign pw_hi  [8*v +: 8] = r_regs[7*v + 3];
        assign control[8*v +: 8] = r_regs[7*v + 4];
        assign att_dec[8*v +: 8] = r_regs[7*v + 5];
        assign sus_rel[8*v +: 8] = r_regs[7*v + 6];
    end

    assign fc_lo    = r_regs[21];
    assign fc_hi    = r_regs[22];
    assign res_filt = r_regs[23];
    assign mode_vol = r_regs[24];
endmodule

// File: tb/tb_sid_regfile.sv
module tb_sid_regfile;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce_1m = 1'b0;
    logic [23:0] freq_lo, freq_hi, pw_lo, pw_hi, control, att_dec, sus_rel;
    logic [7:0]  fc_lo, fc_hi, res_filt, mode_vol;
    logic [7:0]  pot_x = 8'h00, pot_y = 8'h00, osc3 = 8'h00, env3 = 8'h00;
    int          checks = 0;
    int          errors = 0;

    sid_regfile_if bus ();

    sid_regfile #(.DECAY_CYCLES(16'd16)) dut (
        .clock(clock), .reset(reset), .ce_1m(ce_1m), .bus(bus),
        .freq_lo(freq_lo), .freq_hi(freq_hi), .pw_lo(pw_lo), .pw_hi(pw_hi),
        .control(control), .att_dec(att_dec), .sus_rel(sus_rel),
        .fc_lo(fc_lo), .fc_hi(fc_hi), .res_filt(res_filt), .mode_vol(mode_vol),
        .pot_x(pot_x), .pot_y(pot_y), .osc3(osc3), .env3(env3)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the active edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic ce);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d; ce_1m = ce;
        step();
        bus.cs = 1'b0; bus.we = 1'b0; ce_1m = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ce_1m = 1'b1;
            step();
            ce_1m = 1'b0;
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        step();
        bus.cs = 1'b0;
        chk({tag, "_novld"}, {31'd0, bus.rd_valid}, 32'd0);
        step();
        chk({tag, "_data"}, {24'd0, bus.data_out}, {24'd0, exp});
        chk({tag, "_vld"}, {31'd0, bus.rd_valid}, 32'd1);
        step();
        chk({tag, "_pulse"}, {31'd0, bus.rd_valid}, 32'd0);
    endtask

    initial begin
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 5'h00; bus.data_in = 8'h00;
        #22;
        chk("rst_freq_lo", {8'd0, freq_lo}, 32'd0);
        chk("rst_dout", {24'd0, bus.data_out}, 32'd0);
        chk("rst_vld", {31'd0, bus.rd_valid}, 32'd0);
        reset = 1'b1;
        step();

        // basic decode
        wr(5'h00, 8'h34, 1'b0);
        wr(5'h01, 8'h12, 1'b0);
        wr(5'h0B, 8'h41, 1'b0);
        chk("freq_lo", {8'd0, freq_lo}, 32'h000034);
        chk("freq_hi", {8'd0, freq_hi}, 32'h000012);
        chk("control", {8'd0, control}, 32'h004100);
        chk("pw_lo0", {8'd0, pw_lo}, 32'd0);
        chk("sus_rel0", {8'd0, sus_rel}, 32'd0);
        chk("filt0", {fc_lo, fc_hi, res_filt, mode_vol}, 32'd0);

        // write then read of a write-only register returns the latch
        wr(5'h04, 8'h5A, 1'b0);
        chk("control_v1", {8'd0, control}, 32'h00415A);
        rd(5'h04, 8'h5A, "rd04");
        rd(5'h1E, 8'h5A, "rd1E");

        // decay: 16 ticks after a write
        wr(5'h18, 8'h0F, 1'b0);
        chk("mode_vol", {24'd0, mode_vol}, 32'h0F);
        ticks(15);
        rd(5'h18, 8'h0F, "dec15");
        ticks(1);
        rd(5'h18, 8'h00, "dec16");

        // write coinciding with tick 10 restarts decay
        wr(5'h18, 8'h0F, 1'b0);
        ticks(9);
        wr(5'h07, 8'h77, 1'b1);
        chk("freq_lo_v2", {8'd0, freq_lo}, 32'h007734);
        ticks(15);
        rd(5'h00, 8'h77, "restart15");
        ticks(1);
        rd(5'h00, 8'h00, "restart16");

        // read-only sources load the latch
        osc3 = 8'hA7;
        rd(5'h1B, 8'hA7, "osc3");
        rd(5'h05, 8'hA7, "latch_osc3");
        env3 = 8'h5E;
        rd(5'h1C, 8'h5E, "env3");

        // back-to-back reads of POTX then POTY
        pot_x = 8'h3C; pot_y = 8'hC3;
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 5'h19;
        step();
        bus.addr = 5'h1A;
        step();
        bus.cs = 1'b0;
        chk("b2b_potx", {23'd0, bus.rd_valid, bus.data_out}, 32'h13C);
        step();
        chk("b2b_poty", {23'd0, bus.rd_valid, bus.data_out}, 32'h1C3);
        step();
        chk("b2b_end", {31'd0, bus.rd_valid}, 32'd0);

        // write to unmapped address: latch only; cs=0 ignored
        wr(5'h1D, 8'h66, 1'b0);
        chk("unmapped_regs", {8'd0, freq_lo}, 32'h007734);
        bus.cs = 1'b0; bus.we = 1'b1; bus.addr = 5'h00; bus.data_in = 8'hFF;
        step();
        bus.we = 1'b0;
        chk("cs0_ignored", {8'd0, freq_lo}, 32'h007734);
        rd(5'h00, 8'h66, "unmapped_latch");

        // write with ce_1m while counter is 1: no clear, full reload
        wr(5'h02, 8'h11, 1'b0);
        ticks(15);
        wr(5'h02, 8'h99, 1'b1);
        chk("pw_lo", {8'd0, pw_lo}, 32'h000099);
        rd(5'h02, 8'h99, "coinc0");
        ticks(15);
        rd(5'h02, 8'h99, "coinc15");
        ticks(1);
        rd(5'h02, 8'h00, "coinc16");

        // reset between a read request and its response
        osc3 = 8'hB4;
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 5'h1B;
        step();
        bus.cs = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_mid_vld", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_mid_regs", {8'd0, freq_lo | pw_lo | control}, 32'd0);
        chk("rst_mid_filt", {fc_lo, fc_hi, res_filt, mode_vol}, 32'd0);
        step();
        chk("rst_hold_vld", {23'd0, bus.rd_valid, bus.data_out}, 32'd0);
        #3 reset = 1'b1;
        step();
        chk("rel_vld", {23'd0, bus.rd_valid, bus.data_out}, 32'd0);
        rd(5'h00, 8'h00, "rel_latch");
        wr(5'h16, 8'h80, 1'b0);
        chk("fc_hi", {24'd0, fc_hi}, 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sid_regfile.md
Name: sid_regfile

Overview:
CPU-facing register writer and reader for one SID instance (3 voices plus filter/volume). Decodes 8-bit bus writes into the per-voice register buses that feed the voice blocks, and the filter register buses. Serves CPU reads of POTX/POTY/OSC3/ENV3. Models the SID's decaying data-bus latch for reads of write-only and unmapped addresses.

Parameters:
DECAY_CYCLES, 16'd8192, ce_1m ticks after the last bus access before the bus latch decays to 8'h00 (must be ≥1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ce_1m  in  1  1 MHz clock enable; used only for decay timing
cs  in  1  chip select, sampled on clock
we  in  1  1 = write, 0 = read; valid with cs
addr  in  5  register address 0x00-0x1F
data_in  in  8  write data
data_out  out  8  registered read data
rd_valid  out  1  one-cycle pulse: data_out is valid
freq_lo, freq_hi, pw_lo, pw_hi, control, att_dec, sus_rel  out  24 each  packed per voice; voice1=[7:0], voice2=[15:8], voice3=[23:16]
fc_lo  out  8  reg 0x15 (voice filter uses [2:0])
fc_hi  out  8  reg 0x16
res_filt  out  8  reg 0x17
mode_vol  out  8  reg 0x18
pot_x, pot_y  in  8 each  paddle values
osc3, env3  in  8 each  voice-3 osc_out / env_out

Behaviour:
- Register map: voice n (0..2) at base 7n. Offsets: +0 freq_lo, +1 freq_hi, +2 pw_lo, +3 pw_hi, +4 control, +5 att_dec, +6 sus_rel. 0x15-0x18 are filter/volume. 0x19 POTX, 0x1A POTY, 0x1B OSC3, 0x1C ENV3 are read-only. 0x1D-0x1F are unmapped.
- Write (cs & we at a clock edge): the target register takes data_in at that edge, all 8 bits stored. The bus latch takes data_in. The decay counter reloads to DECAY_CYCLES. A write to a read-only or unmapped address changes no register but still loads the latch and reloads the counter. rd_valid stays 0.
- Read (cs & !we at edge N): data_out is updated at edge N+1 and rd_valid=1 for exactly that cycle. Latency is 1 and there is no stall. Back-to-back reads on consecutive cycles are allowed.
- Read data:
  - 0x19-0x1C return the input sampled at edge N. The latch takes that value and the counter reloads.
  - All other addresses (0x00-0x18, 0x1D-0x1F) return the current latch value. The latch and counter are unchanged.
- data_out holds its last value when no read is in progress.
- Decay: on each ce_1m with no bus access that cycle, if counter ≠ 0 then counter decrements. When the counter goes 1→0, the latch clears to 8'h00 on the same edge. With the counter at 0, the latch stays at 0.
- Simultaneous access and ce_1m: the access wins. The counter loads DECAY_CYCLES and does not decrement that cycle.
- Writes never change data_out.
- cs=0: we, addr and data_in are ignored.
- Reset (reset=0, asynchronous, any time including mid-read): all register outputs 8'h00, latch 8'h00, counter 0, data_out 8'h00, rd_valid 0. A read issued in the cycle that reset asserts is dropped. After release, the first edge with cs behaves normally.
- Counter width is 16 bits. There is no wrap: the counter saturates at 0.

Test Plan:
- Use DECAY_CYCLES=16 for all scenarios.
- Write 0x00←0x34, 0x01←0x12, 0x0B←0x41 -> freq_lo[7:0]=0x34, freq_hi[7:0]=0x12, control[15:8]=0x41; every other output is 0.
- Write 0x04←0x5A, then read 0x04 on the next cycle -> data_out=0x5A one cycle later with a single rd_valid pulse. Read 0x1E -> 0x5A.
- Write 0x18←0x0F, then 16 ce_1m ticks with no access -> reads of 0x18 return 0x0F through tick 15 and 0x00 from tick 16. Repeat with a write at tick 10 -> the decay restarts and the latch holds the new value for 16 more ticks.
- Set osc3=0xA7, read 0x1B -> data_out=0xA7. Then read 0x05 -> 0xA7, because the latch was loaded by the OSC3 read.
- Write coinciding with a ce_1m while the counter=1 -> the latch holds the written value, counter=16, and no clear occurs.
- Drive reset low between a read request and its response -> rd_valid never pulses and all outputs are 0. After release, write 0x16←0x80 -> fc_hi=0x80.
